// File: rtl/layer_output_collector.sv
// layer_output_collector: captures one activation per neuron into a capture
// bank, then streams the completed vector word by word from a send bank so
// that capture of the next vector overlaps streaming of the current one.
// Optional feature macro: LAYER_ARGMAX_EN (running argmax over each streamed
// vector, reported alongside layer_done).

// One capture slot: holds a neuron's activation until the bank is transferred.
module layer_output_collector_slot #(
    parameter int ROM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [ROM_WIDTH-1:0] din,
    input  logic                 xfer,
    output logic [ROM_WIDTH-1:0] cap,
    output logic                 flag,
    output logic                 drop
);
    // A second pulse before transfer is lost; a pulse on the transfer edge
    // belongs to the next vector.
    assign drop = valid && flag && !xfer;

    // Capture on first pulse (or on a transfer edge); flag clears on transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap  <= '0;
            flag <= 1'b0;
        end else if (valid && (!flag || xfer)) begin
            cap  <= din;
            flag <= 1'b1;
        end else if (xfer) begin
            flag <= 1'b0;
        end
    end
endmodule

module layer_output_collector #(
    parameter int NUM_NEURONS = 30,
    parameter int ROM_WIDTH   = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_SHIFT   = 0,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_NEURONS*ROM_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]           neuron_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IDX_WIDTH-1:0]             out_idx,
    output logic                             out_last,
    output logic                             layer_done,
    output logic                             overflow,
    output logic [IDX_WIDTH-1:0]             max_idx,
    output logic                             max_valid
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_nxt;
    logic [NUM_NEURONS-1:0][ROM_WIDTH-1:0] cap, snd;
    logic [NUM_NEURONS-1:0]                flag, drop;
    logic [IDX_WIDTH-1:0]                  idx, idx_nxt;
    logic                                  full, xfer, accept, is_last;
    logic [DATA_WIDTH-1:0]                 word;

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_slot
            layer_output_collector_slot #(.ROM_WIDTH(ROM_WIDTH)) u_slot (
                .clk   (clk),
                .rst   (rst),
                .valid (neuron_valid[g]),
                .din   (neuron_out[g*ROM_WIDTH +: ROM_WIDTH]),
                .xfer  (xfer),
                .cap   (cap[g]),
                .flag  (flag[g]),
                .drop  (drop[g])
            );
        end
    endgenerate

    assign full      = &flag;
    assign out_valid = (state == SEND);
    assign accept    = out_valid && out_ready;
    assign is_last   = (idx == LAST_IDX);
    assign word      = DATA_WIDTH'(snd[idx]) << OUT_SHIFT;
    assign out_data  = out_valid ? word : '0;
    assign out_idx   = idx;
    assign out_last  = out_valid && is_last;

    // Next state: start a vector from IDLE when full, or chain straight into
    // the next vector when the last word is accepted and the bank is full.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (full) begin
                    xfer      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (is_last) begin
                        idx_nxt = '0;
                        if (full) xfer = 1'b1;
                        else      state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, index, send bank and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            snd        <= '0;
            layer_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            layer_done <= accept && is_last;
            overflow   <= overflow | (|drop);
            if (xfer) snd <= cap;
        end
    end

`ifdef LAYER_ARGMAX_EN
    logic [ROM_WIDTH-1:0] run_max;
    logic [IDX_WIDTH-1:0] run_idx;

    // Running argmax over accepted words; word 0 reloads, strict > keeps the
    // lowest index on ties. Holds through the layer_done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max <= '0;
            run_idx <= '0;
        end else if (accept && ((idx == '0) || (snd[idx] > run_max))) begin
            run_max <= snd[idx];
            run_idx <= idx;
        end
    end

    assign max_valid = layer_done;
    assign max_idx   = layer_done ? run_idx : '0;
`else
    assign max_valid = 1'b0;
    assign max_idx   = '0;
`endif
endmodule

// File: tb/tb_layer_output_collector.sv
// Bench for layer_output_collector: directed scenarios then random traffic,
// all checked against a vector-level reference model.
module tb_layer_output_collector;
    localparam int N  = 4;
    localparam int RW = 8;
    localparam int DW = 16;
    localparam int SH = 0;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*RW-1:0] neuron_out = '0;
    logic [N-1:0]  neuron_valid = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          layer_done;
    logic          overflow;
    logic [IW-1:0] max_idx;
    logic          max_valid;

    layer_output_collector #(
        .NUM_NEURONS(N), .ROM_WIDTH(RW), .DATA_WIDTH(DW), .OUT_SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .neuron_out(neuron_out), .neuron_valid(neuron_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .layer_done(layer_done),
        .overflow(overflow), .max_idx(max_idx), .max_valid(max_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending capture vector, vector being streamed, and
    // how many of its words remain to be delivered.
    logic [RW-1:0] m_cap[N];
    logic [RW-1:0] m_cur[N];
    bit            m_flg[N];
    int            m_rem;
    bit            m_ovf;
    bit            m_done;
    int            m_max;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_cap[i] = '0; m_cur[i] = '0; m_flg[i] = 0;
        end
        m_rem = 0; m_ovf = 0; m_done = 0; m_max = 0;
    endtask

    task automatic model_step(input logic [N-1:0] v, input logic [N*RW-1:0] d, input bit rdy);
        bit acc, full, xfer, oldf;
        acc  = (m_rem > 0) && rdy;
        full = 1;
        for (int i = 0; i < N; i++) full &= m_flg[i];
        // The pending vector moves out once the streamer is free or is
        // handing off its final word this cycle.
        xfer   = full && (m_rem == 0 || (m_rem == 1 && acc));
        m_done = acc && (m_rem == 1);
        if (m_done) begin
            m_max = 0;
            for (int i = 1; i < N; i++) if (m_cur[i] > m_cur[m_max]) m_max = i;
        end
        if (xfer) begin
            for (int i = 0; i < N; i++) m_cur[i] = m_cap[i];
            m_rem = N;
        end else if (acc) begin
            m_rem--;
        end
        for (int i = 0; i < N; i++) begin
            oldf = m_flg[i];
            if (xfer) m_flg[i] = 0;
            if (v[i]) begin
                if (!oldf || xfer) begin
                    m_cap[i] = d[i*RW +: RW];
                    m_flg[i] = 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int pos;
        logic [DW-1:0] w;
        pos = N - m_rem;
        check("out_valid", out_valid, 32'(m_rem > 0));
        if (m_rem > 0) begin
            w = DW'(m_cur[pos]);
            w = w << SH;
            check("out_idx", out_idx, pos);
            check("out_data", out_data, w);
            check("out_last", out_last, 32'(m_rem == 1));
        end
        check("layer_done", layer_done, m_done);
        check("overflow", overflow, m_ovf);
`ifdef LAYER_ARGMAX_EN
        check("max_valid", max_valid, m_done);
        if (m_done) check("max_idx", max_idx, m_max);
`else
        check("max_valid", max_valid, 0);
        check("max_idx", max_idx, 0);
`endif
    endtask

    // One cycle: check at the negedge, drive, advance the model, next negedge.
    task automatic step(input logic [N-1:0] v, input logic [N*RW-1:0] d, input bit rdy);
        check_outputs();
        neuron_valid = v;
        neuron_out   = d;
        out_ready    = rdy;
        model_step(v, d, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        neuron_valid = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_layer_done", layer_done, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N-1:0]    rv;
    logic [N*RW-1:0] rd;

    initial begin
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // All neurons at once.
        idle(2);
        step(4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
        idle(7);

        // Staggered arrivals: 2, 0, 3, 1.
        step(4'b0100, {8'h00, 8'hA3, 8'h00, 8'h00}, 1'b1);
        step(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA1}, 1'b1);
        step(4'b1000, {8'hA4, 8'h00, 8'h00, 8'h00}, 1'b1);
        step(4'b0010, {8'h00, 8'h00, 8'hA2, 8'h00}, 1'b1);
        idle(7);

        // Backpressure 1,0,0,1,...
        step(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        for (int i = 0; i < 14; i++) step('0, '0, (i % 4 == 0) || (i % 4 == 3));
        idle(3);

        // Back-to-back: second vector captured during the first stream.
        step(4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
        step('0, '0, 1'b1);
        step(4'b1111, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
        idle(10);

        // Overflow: neuron 1 twice, first value kept; then reset mid-stream.
        step(4'b0010, {8'h00, 8'h00, 8'h11, 8'h00}, 1'b1);
        step(4'b0010, {8'h00, 8'h00, 8'h22, 8'h00}, 1'b1);
        step(4'b1101, {8'h0D, 8'h0C, 8'h00, 8'h0A}, 1'b1);
        idle(4);
        step(4'b1111, {8'h08, 8'h07, 8'h06, 8'h05}, 1'b1);
        idle(3);
        do_reset();
        idle(3);

        // Argmax with a tie: {0x50,0x90,0x90,0x10} -> index 1.
        step(4'b1111, {8'h10, 8'h90, 8'h90, 8'h50}, 1'b1);
        idle(7);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 5) == 0);
                rd = $urandom;
                step(rv, rd, $urandom_range(0, 3) != 0);
            end
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
